// File: rtl/pe_data_tx_pkg.sv
// Shared PE definitions: transmit FSM encoding, default psum width, pointer sizing helper.
// Imported by the PE transmit port and its buffer.
package pe_data_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } tx_state_e;

  localparam int PSUM_WIDTH = 20;

  // Pointer width for a power-of-two buffer; the occupancy counter is one bit wider.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/pe_tx_fifo.sv
// Synchronous FIFO with registered storage; head is visible the cycle after a push.
// push is ignored when full, pop when empty; full/empty come from an occupancy counter.
module pe_tx_fifo
  import pe_data_tx_pkg::*;
#(
  parameter int WIDTH = PSUM_WIDTH + 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = ptr_width(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (occ_q == (AW+1)'(DEPTH));
  assign empty   = (occ_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Head reads as zero when empty so the port shows all-zero outputs after reset.
  assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pe_data_tx.sv
// PE transmit port: buffers a burst of psums and sends them under valid/ready, tagging the last word.
// One cycle src-to-out latency; src_ready depends only on local state, never on data_out_ready.
module pe_data_tx
  import pe_data_tx_pkg::*;
#(
  parameter int DATA_OUT_WIDTH = PSUM_WIDTH,
  parameter int BUFFER_DEPTH   = 4,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CNT_WIDTH-1:0]      tx_len,
  input  logic                      src_valid,
  input  logic [DATA_OUT_WIDTH-1:0] src_data,
  output logic                      src_ready,
  output logic                      data_out_valid,
  output logic [DATA_OUT_WIDTH-1:0] data_out,
  output logic                      data_out_last,
  input  logic                      data_out_ready,
  output logic                      busy,
  output logic                      done
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  tx_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] accept_cnt_q, accept_cnt_d;
  logic [CNT_WIDTH-1:0] sent_cnt_q, sent_cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [DATA_OUT_WIDTH:0] fifo_head;
  logic                    fifo_full, fifo_empty;
  logic                    push, pop, push_last, head_last;

  assign src_ready = (state_q == ST_SEND) & ~fifo_full & (accept_cnt_q < len_q);
  assign push      = src_valid & src_ready;
  assign push_last = (accept_cnt_q == (len_q - CNT_ONE));

  assign data_out_valid = ~fifo_empty;
  assign data_out       = fifo_head[DATA_OUT_WIDTH-1:0];
  assign head_last      = fifo_head[DATA_OUT_WIDTH];
  assign data_out_last  = head_last;
  assign pop            = data_out_valid & data_out_ready;

  assign busy = busy_q;
  assign done = done_q;

  pe_tx_fifo #(
    .WIDTH (DATA_OUT_WIDTH + 1),
    .DEPTH (BUFFER_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({push_last, src_data}),
    .pop      (pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    accept_cnt_d = accept_cnt_q;
    sent_cnt_d   = sent_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (tx_len != '0) begin
            len_d        = tx_len;
            accept_cnt_d = '0;
            sent_cnt_d   = '0;
            state_d      = ST_SEND;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SEND: begin
        if (push) begin
          accept_cnt_d = accept_cnt_q + CNT_ONE;
        end
        if (pop) begin
          sent_cnt_d = sent_cnt_q + CNT_ONE;
        end
        // The burst ends when its tagged word leaves, not when it is accepted.
        if (pop && head_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      accept_cnt_q <= '0;
      sent_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      accept_cnt_q <= accept_cnt_d;
      sent_cnt_q   <= sent_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: doc/pe_data_tx.md
Name: pe_data_tx

Overview:
- Transmit-side data port of a PE.
- Accepts a burst of result words (psums) from the PE datapath and buffers them in a small FIFO.
- Drives them out to the cluster network / GLB under a valid/ready handshake with backpressure.
- Tags the final word of each burst with last and signals completion. It is the sending counterpart of the PE's input data FIFO.

Parameters:
- DATA_OUT_WIDTH, 20, width of one output word (psum).
- BUFFER_DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_WIDTH, 8, width of the burst length and word counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a burst when in IDLE.
- tx_len  in  CNT_WIDTH  number of words in the burst; sampled when start is accepted.
- src_valid  in  1  PE datapath has a word.
- src_data  in  DATA_OUT_WIDTH  word from the PE datapath.
- src_ready  out  1  block accepts src_data this cycle.
- data_out_valid  out  1  output word valid.
- data_out  out  DATA_OUT_WIDTH  output word.
- data_out_last  out  1  current output word is the last of the burst.
- data_out_ready  in  1  downstream accepts the word.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the burst completes.

Behaviour:
- Reset: every output is 0. FSM goes to IDLE, FIFO is emptied, pointers and counters are cleared. Reset mid-burst abandons the burst and emits no done.
- FSM states: IDLE, SEND, DONE.
  - IDLE: start with tx_len != 0 latches len and clears accept_cnt and sent_cnt, then goes to SEND.
  - IDLE: start with tx_len == 0 goes to DONE with no data transferred.
  - SEND: go to DONE in the cycle the word with last=1 is handshaken on the output.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
  - start is ignored outside IDLE.
- Push side:
  - src_ready = (state == SEND) & ~full & (accept_cnt < len). It has no combinational dependence on data_out_ready.
  - A push occurs when src_valid & src_ready.
  - Each push stores {last, data}, where last = (accept_cnt == len-1), then increments accept_cnt.
- Pop side:
  - data_out_valid = ~empty.
  - data_out and data_out_last come from the head entry.
  - A pop occurs when data_out_valid & data_out_ready; sent_cnt increments on each pop.
- Latency: a word pushed in cycle t is visible on data_out in cycle t+1 at the earliest. There is no combinational src-to-out path.
- Output stability: while data_out_valid=1 and data_out_ready=0, data_out and data_out_last hold their values and valid does not drop.
- Full/empty:
  - Pointers are log2(BUFFER_DEPTH) bits and wrap naturally.
  - full/empty are resolved with an occupancy counter of log2(BUFFER_DEPTH)+1 bits.
  - Simultaneous push and pop leaves occupancy unchanged and is legal at any occupancy except a push when full; src_ready is already 0 when full.
- Ordering: output order equals push order, with no loss or duplication.
- Arithmetic: counters are unsigned CNT_WIDTH bits; len ≤ 2^CNT_WIDTH − 1.
- Extra src words: once accept_cnt reaches len, src_ready stays 0 until the next burst. Extra src_valid is not consumed.

Decomposition:
- Shared PE package:
  - FSM state encoding: IDLE=2'd0, SEND=2'd1, DONE=2'd2.
  - Default psum width constant (20).
- Sub-module pe_tx_fifo: a parameterised synchronous FIFO of width DATA_OUT_WIDTH+1 with push/pop, full/empty and registered storage.
- The top level holds the FSM and counters.

Test Plan:
- Reset: assert rst for 2 cycles -> src_ready, data_out_valid, data_out_last, busy, done are all 0; after release, state is IDLE.
- Basic burst: start with tx_len=3, src_valid=1 with 0x10, 0x11, 0x12, data_out_ready=1 -> 0x10 appears on data_out one cycle after its push, then 0x11 and 0x12 on consecutive cycles. data_out_last=1 only with 0x12; done pulses one cycle after the 0x12 handshake; busy then falls.
- Backpressure: tx_len=6, data_out_ready=0 -> exactly 4 pushes, after which src_ready=0 and data_out holds 0x10 steady. Raise ready -> six words out in order, last on the 6th.
- Zero length: start with tx_len=0 -> done pulses the next cycle, data_out_valid never rises, src_ready stays 0.
- Concurrency/wrap: tx_len=10, randomised src_valid and data_out_ready with push and pop in the same cycle at occupancy 3 -> occupancy stays 3; pointers wrap twice; all 10 words arrive in order with no extras accepted.
- Mid-op control:
  - start asserted while busy -> ignored, and the burst completes with its original length.
  - rst asserted mid-burst -> outputs 0 the next cycle and no done pulse.
  - A new burst then runs cleanly.
